load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Requester side of the data-memory port: takes one RV32I load/store from the datapath, drives word-wide
//  memory requests, extracts and extends load data (LB/LH/LW/LBU/LHU) and performs sub-word stores (SB/SH)
//  as read-modify-write. Sits between execute stage and data_memory; one transaction in flight.
// PARAMETERS
//  MEM_AW   5   word-address width to memory (32 words); byte-address bits above MEM_AW+1 ignored
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-high; forces IDLE
//  req_valid   in   1       core request; accepted when req_valid & req_ready
//  req_ready   out  1       1 only in IDLE
//  req_store   in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3 (size/sign)
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data (low byte/half used for SB/SH)
//  resp_valid  out  1       one-cycle completion pulse (no back-pressure)
//  resp_rdata  out  32      load result, valid with resp_valid; 0 for stores/errors
//  resp_err    out  1       valid with resp_valid: illegal funct3 (or misaligned, see CONFIGURATION)
//  mem_req     out  1       memory request; held stable until mem_gnt
//  mem_we      out  1       1 = full-word write
//  mem_addr    out  MEM_AW  word address (req_addr[MEM_AW+1:2])
//  mem_wdata   out  32      write word
//  mem_gnt     in   1       request accepted this cycle (writes complete at gnt)
//  mem_rvalid  in   1       read data valid, >=1 cycle after gnt
//  mem_rdata   in   32      read word
// BEHAVIOUR
//  Reset: state IDLE; resp_valid/resp_err/mem_req/mem_we 0; resp_rdata, mem_wdata, mem_addr 0; req_ready 1.
//  States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP. Request fields latched on acceptance.
//  IDLE: accept -> illegal funct3 (load 3/6/7, store >=3) ? RESP(err) : load or SB/SH ? RD_REQ : SW ? WR_REQ.
//  RD_REQ: mem_req=1, mem_we=0; mem_gnt -> RD_WAIT. RD_WAIT: mem_rvalid -> load: RESP; SB/SH: merge -> WR_REQ.
//  WR_REQ: mem_req=1, mem_we=1, mem_wdata = merged word (SW: req_wdata); mem_gnt -> RESP.
//  RESP: resp_valid=1 for exactly one cycle -> IDLE. Back-to-back: next req accepted in following IDLE.
//  Lane select by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend, LBU/LHU
//   zero-extend, LW passthrough. Merge replaces only addressed lanes; other bytes from read word.
//  Min latency (gnt same cycle, rvalid next): load/SB/SH-read accept->resp_valid 3 cycles; SW 2; SB/SH 4.
//  mem_rvalid outside RD_WAIT and mem_gnt outside *_REQ are ignored. Reset mid-transaction: mem_req drops
//   asynchronously, no write issued, no resp_valid; late mem_rvalid after reset ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> no memory access,
//   RESP next cycle with resp_err=1, resp_rdata=0.
//  Undefined: low address bits below access size forced to 0 (half at addr&~1, word at addr&~3), no error.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), lsu_state_e enum, lane-select/extend functions.
//  Sub-module lsu_align (combinational): load extract+extend and store merge from word, funct3, addr[1:0].
// TESTING
//  1 mem word 3 = 32'h8899_AABB; LB addr 0x0F -> resp_rdata 32'hFFFF_FF88; LBU -> 32'h0000_0088, resp_err 0.
//  2 same word; SB wdata 32'h0000_0012 addr 0x0D -> one read then write 32'h8899_12BB to word 3.
//  3 SW 32'hDEAD_BEEF addr 0x10, gnt held low 3 cycles -> mem_req/addr/wdata stable, resp 1 cycle after gnt.
//  4 LH addr 0x11: with LSU_MISALIGN_TRAP_EN resp_err=1, no mem_req; without, reads half at 0x10.
//  5 funct3=3 load -> resp_err=1, no mem_req; then LW issued next IDLE cycle completes normally.
//  6 assert reset in RD_WAIT -> mem_req 0, req_ready 1, no resp_valid; stale mem_rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_pkg : shared funct3 encodings, FSM state type and lane helpers for the  |
// |           load/store unit.                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Drop the address bits below the access size so halves/words land on their own lanes.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] off);
    return w[8*off +: 8];
  endfunction

  function automatic logic [15:0] sel_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_align : combinational load extract/extend and sub-word store merge.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic w_signed;
  assign w_signed = ~funct3[2];

  always_comb begin
    load_data  = word;
    merge_data = word;
    case (funct3[1:0])
      2'b00: begin
        load_data                  = ext_byte(sel_byte(word, offset), w_signed);
        merge_data[8*offset +: 8]  = wdata[7:0];
      end
      2'b01: begin
        load_data = ext_half(sel_half(word, offset[1]), w_signed);
        if (offset[1]) merge_data[31:16] = wdata[15:0];
        else           merge_data[15:0]  = wdata[15:0];
      end
      default: begin
        load_data  = word;
        merge_data = wdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : RV32I load/store requester towards a word-wide memory;   |
// |   sub-word stores done as read-modify-write. LSU_MISALIGN_TRAP_EN turns    |
// |   misaligned half/word accesses into error responses.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state, w_state_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_offset;
  logic [MEM_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              w_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;
  logic              w_unused;

  assign w_unused = ^{req_addr[31:MEM_AW+2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = !f3_legal(req_store, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_err = !f3_legal(req_store, req_funct3);
`endif

  lsu_align u_align (
    .word       (mem_rdata),
    .wdata      (r_wdata),
    .funct3     (r_funct3),
    .offset     (r_offset),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                                 w_state_next = ST_RESP;
          else if (req_store && req_funct3 == F3_W)  w_state_next = ST_WR_REQ;
          else                                       w_state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) w_state_next = r_store ? ST_WR_REQ : ST_RESP;
      end
      ST_WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured once on acceptance; r_wdata is later reused for the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_offset <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_offset <= align_off(req_funct3, req_addr[1:0]);
        r_addr   <= req_addr[MEM_AW+1:2];
        r_wdata  <= req_wdata;
        r_rdata  <= 32'd0;
        r_err    <= w_err;
      end else if (r_state == ST_RD_WAIT && mem_rvalid) begin
        if (r_store) r_wdata <= w_merge_data;
        else         r_rdata <= w_load_data;
      end
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = resp_valid & r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Bench for load_store_unit: byte-addressed memory model, responder with programmable
// grant/rvalid delays, and a per-cycle monitor checking responses and writes.
module tb_load_store_unit;

  localparam int MEM_AW = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int idx; logic [31:0] data; } wr_t;
  typedef struct { logic st; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; int gd; int rd; } vec_t;

  resp_t       exp_resp[$];
  wr_t         exp_wr[$];
  logic [31:0] mem [32];
  logic [31:0] model_mem [32];
  int          gnt_delay = 0;
  int          rvalid_delay = 0;
  int          req_cycles = 0;
  int          resp_count = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: grant after gnt_delay waiting cycles, read data rvalid_delay cycles after grant.
  initial begin : responder
    int wait_cnt;
    int rd_cnt;
    int rd_idx;
    bit rd_pending;
    wait_cnt = 0; rd_cnt = 0; rd_idx = 0; rd_pending = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[rd_idx];
          rd_pending = 0;
        end else rd_cnt--;
      end
      if (mem_req && !reset) begin
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else begin
            rd_pending = 1;
            rd_idx     = int'(mem_addr);
            rd_cnt     = rvalid_delay;
          end
        end
      end else wait_cnt = 0;
    end
  end

  initial begin : monitor
    logic              p_req, p_gnt, p_we;
    logic [MEM_AW-1:0] p_addr;
    logic [31:0]       p_wdata;
    p_req = 0; p_gnt = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) p_req = 0;
      else begin
        if (p_req && !p_gnt) begin
          check("mem_req_held", 32'(mem_req), 32'd1);
          check("mem_we_held", 32'(mem_we), 32'(p_we));
          check("mem_addr_held", 32'(mem_addr), 32'(p_addr));
          check("mem_wdata_held", mem_wdata, p_wdata);
        end
        if (mem_req) req_cycles++;
        if (mem_req && mem_gnt && mem_we) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("write_addr", 32'(mem_addr), 32'(w.idx));
            check("write_data", mem_wdata, w.data);
          end
        end
        if (resp_valid) begin
          resp_count++;
          last_rdata = resp_rdata;
          last_err   = resp_err;
          if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
          end else begin
            resp_t r;
            r = exp_resp.pop_front();
            check("resp_rdata", resp_rdata, r.rdata);
            check("resp_err", 32'(resp_err), 32'(r.err));
          end
        end
        p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      end
    end
  end

  // Compute expected outcome from the ISA rules, then drive the request and wait for completion.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          size, idx, sh, lat, lat_exp;
    logic        legal, mis, err;
    logic [31:0] ea, mask, v, nw;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis   = (a % 32'(size)) != 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = !legal || mis;
`else
    err = !legal;
`endif
    ea   = a - (a % 32'(size));
    idx  = int'((ea >> 2) % 32'd32);
    sh   = int'(ea % 32'd4) * 8;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
    v    = 32'd0;
    lat_exp = 1;
    if (!err) begin
      if (!st) begin
        v = (model_mem[idx] >> sh) & mask;
        if (!f3[2] && size < 4 && v[size*8-1]) v = v | ~mask;
        lat_exp = 3 + gnt_delay + rvalid_delay;
      end else begin
        nw = (model_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
        model_mem[idx] = nw;
        exp_wr.push_back('{idx, nw});
        lat_exp = (size == 4) ? 2 + gnt_delay : 4 + 2 * gnt_delay + rvalid_delay;
      end
    end
    exp_resp.push_back('{v, err});

    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready 0 for %0d cycles, expected 1", lat);
      req_valid = 1'b0;
      exp_resp.delete(); exp_wr.delete();
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    #2;
    while (exp_resp.size() != 0 && lat < 60) begin @(negedge clk); #2; lat++; end
    if (exp_resp.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles, expected one", lat);
      exp_resp.delete(); exp_wr.delete();
    end else check("latency", 32'(lat), 32'(lat_exp));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   rc, n;
    vec_t vecs[14];
    for (int i = 0; i < 32; i++) begin
      mem[i]       = 32'h1357_9BDF + 32'h0101_0101 * 32'(i);
      model_mem[i] = mem[i];
    end
    mem[3] = 32'h8899_AABB; model_mem[3] = 32'h8899_AABB;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk); #2;

    send(1'b0, 3'd0, 32'h0F, 32'd0);
    check("pin_lb", last_rdata, 32'hFFFF_FF88);
    send(1'b0, 3'd4, 32'h0F, 32'd0);
    check("pin_lbu", last_rdata, 32'h0000_0088);
    check("pin_lbu_err", 32'(last_err), 32'd0);

    rc = req_cycles;
    send(1'b1, 3'd0, 32'h0D, 32'h0000_0012);
    check("pin_sb_word", mem[3], 32'h8899_12BB);
    check("sb_req_cycles", 32'(req_cycles - rc), 32'd2);

    gnt_delay = 3;
    send(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    gnt_delay = 0;
    check("pin_sw_word", mem[4], 32'hDEAD_BEEF);

    rc = req_cycles;
    send(1'b0, 3'd1, 32'h11, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("pin_lh_mis_err", 32'(last_err), 32'd1);
    check("pin_lh_mis_noreq", 32'(req_cycles - rc), 32'd0);
`else
    check("pin_lh_mis_rdata", last_rdata, 32'hFFFF_BEEF);
`endif

    rc = req_cycles;
    send(1'b0, 3'd3, 32'h20, 32'd0);
    check("pin_f3_err", 32'(last_err), 32'd1);
    check("pin_f3_noreq", 32'(req_cycles - rc), 32'd0);
    send(1'b0, 3'd2, 32'h0C, 32'd0);
    check("pin_lw", last_rdata, 32'h8899_12BB);

    vecs = '{
      '{1'b0, 3'd1, 32'h02, 32'd0, 0, 0},
      '{1'b0, 3'd5, 32'h02, 32'd0, 0, 2},
      '{1'b0, 3'd0, 32'h01, 32'd0, 1, 0},
      '{1'b1, 3'd1, 32'h06, 32'hCAFE_7E57, 1, 1},
      '{1'b0, 3'd2, 32'h04, 32'd0, 0, 0},
      '{1'b1, 3'd0, 32'h1F, 32'h0000_00F0, 0, 0},
      '{1'b0, 3'd2, 32'h1C, 32'd0, 2, 1},
      '{1'b1, 3'd5, 32'h08, 32'h1234_5678, 0, 0},
      '{1'b0, 3'd7, 32'h08, 32'd0, 0, 0},
      '{1'b0, 3'd2, 32'h0E, 32'd0, 0, 0},
      '{1'b1, 3'd1, 32'h03, 32'h0000_ABCD, 0, 0},
      '{1'b0, 3'd5, 32'h06, 32'd0, 0, 0},
      '{1'b0, 3'd2, 32'h8C, 32'd0, 0, 0},
      '{1'b0, 3'd0, 32'h1F, 32'd0, 0, 0}
    };
    foreach (vecs[i]) begin
      gnt_delay    = vecs[i].gd;
      rvalid_delay = vecs[i].rd;
      send(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd);
    end
    gnt_delay = 0;

    rvalid_delay = 3;
    req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0C; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    rc = resp_count;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("rst_no_resp", 32'(resp_count - rc), 32'd0);
    check("rst_idle_ready", 32'(req_ready), 32'd1);
    rvalid_delay = 0;

    send(1'b0, 3'd2, 32'h04, 32'd0);
    check("writes_drained", 32'(exp_wr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
